// File: rtl/mrx_io.sv
// Receive-side IO for the MIO link: samples pad data in SDR or DDR, packs it
// into 64-bit words and hands them, with a byte-valid mask, to the receive FIFO.
module mrx_io #(
   parameter int IOW = 8
) (
   input  logic             io_clk,
   input  logic             nreset,
   input  logic             rx_en,
   input  logic             ddr_mode,
   input  logic             lsbfirst,
   input  logic [1:0]       iowidth,
   input  logic             rx_access,
   input  logic [2*IOW-1:0] rx_packet,
   output logic             rx_wait,
   output logic [63:0]      io_packet,
   output logic [7:0]       io_valid,
   input  logic             io_wait,
   output logic             overflow
);

   function automatic logic [6:0] lane_count(input logic [1:0] iw);
      logic [6:0] n;
      case (iw)
         2'b00:   n = 7'd8;
         2'b01:   n = 7'd4;
         2'b10:   n = 7'd2;
         2'b11:   n = 7'd1;
         default: n = 7'd8;
      endcase
      return n;
   endfunction

   function automatic logic [7:0] lane_mask(input logic [1:0] iw);
      logic [7:0] m;
      case (iw)
         2'b00:   m = 8'hFF;
         2'b01:   m = 8'h0F;
         2'b10:   m = 8'h03;
         2'b11:   m = 8'h01;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   // One valid bit per byte touched by a partial word of 'bits' bits.
   function automatic logic [7:0] tail_mask(input logic [6:0] bits);
      logic [6:0] nbytes;
      logic [8:0] m;
      nbytes = (bits + 7'd7) >> 3;
      m      = (9'd1 << nbytes) - 9'd1;
      return m[7:0];
   endfunction

   logic             acc_q, acc_d;
   logic [2*IOW-1:0] pkt_q, pkt_d;
   logic [6:0]       cnt_q, cnt_d;
   logic [63:0]      word_q, word_d;
   logic [63:0]      io_packet_q, io_packet_d;
   logic [7:0]       io_valid_q, io_valid_d;
   logic             overflow_q, overflow_d;
   logic             rx_wait_q, rx_wait_d;

   logic [6:0]       lanes_s, bits_s, cnt_sum_s;
   logic [7:0]       lmask_s, rise_s, fall_s;
   logic [15:0]      beat_s;
   logic [63:0]      word_add_s;
   logic             emit_s, full_s, drain_s;
   logic [63:0]      emit_word_s;
   logic [7:0]       emit_mask_s;

   // Beat formation and the accumulator value after adding this beat.
   always_comb begin
      lanes_s = lane_count(iowidth);
      lmask_s = lane_mask(iowidth);
      rise_s  = pkt_q[7:0] & lmask_s;
      fall_s  = pkt_q[IOW +: 8] & lmask_s;
      if (!ddr_mode) begin
         bits_s = lanes_s;
         beat_s = {8'd0, rise_s};
      end else if (lsbfirst) begin
         bits_s = lanes_s << 1;
         beat_s = ({8'd0, fall_s} << lanes_s) | {8'd0, rise_s};
      end else begin
         bits_s = lanes_s << 1;
         beat_s = ({8'd0, rise_s} << lanes_s) | {8'd0, fall_s};
      end
      cnt_sum_s = cnt_q + bits_s;
      if (lsbfirst) begin
         word_add_s = word_q | ({48'd0, beat_s} << cnt_q[5:0]);
      end else begin
         word_add_s = (word_q << bits_s) | {48'd0, beat_s};
      end
   end

   // Next-state: stage 1, accumulator, emission, holding register, pushback.
   always_comb begin
      acc_d       = rx_access & rx_en;
      pkt_d       = rx_packet;
      cnt_d       = cnt_q;
      word_d      = word_q;
      emit_s      = 1'b0;
      emit_word_s = 64'd0;
      emit_mask_s = 8'd0;
      if (!rx_en) begin
         cnt_d  = 7'd0;
         word_d = 64'd0;
      end else if (acc_q) begin
         if (cnt_sum_s == 7'd64) begin
            emit_s      = 1'b1;
            emit_word_s = word_add_s;
            emit_mask_s = 8'hFF;
            cnt_d       = 7'd0;
            word_d      = 64'd0;
         end else begin
            cnt_d  = cnt_sum_s;
            word_d = word_add_s;
         end
      end else if (cnt_q != 7'd0) begin
         emit_s      = 1'b1;
         emit_word_s = word_q;
         emit_mask_s = tail_mask(cnt_q);
         cnt_d       = 7'd0;
         word_d      = 64'd0;
      end else begin
         cnt_d  = 7'd0;
         word_d = 64'd0;
      end

      full_s      = (io_valid_q != 8'd0);
      drain_s     = full_s & ~io_wait;
      io_packet_d = io_packet_q;
      io_valid_d  = io_valid_q;
      if (emit_s && (!full_s || drain_s)) begin
         io_packet_d = emit_word_s;
         io_valid_d  = emit_mask_s;
      end else if (drain_s) begin
         io_valid_d = 8'd0;
      end else begin
         io_valid_d = io_valid_q;
      end

      // A word emitted into a full, stalled holding register is dropped.
      if (!rx_en) begin
         overflow_d = 1'b0;
      end else if (emit_s && full_s && !drain_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
      rx_wait_d = io_wait | full_s;
   end

   // State registers.
   always_ff @(posedge io_clk or negedge nreset) begin
      if (!nreset) begin
         acc_q       <= 1'b0;
         pkt_q       <= '0;
         cnt_q       <= 7'd0;
         word_q      <= 64'd0;
         io_packet_q <= 64'd0;
         io_valid_q  <= 8'd0;
         overflow_q  <= 1'b0;
         rx_wait_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         pkt_q       <= pkt_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         io_packet_q <= io_packet_d;
         io_valid_q  <= io_valid_d;
         overflow_q  <= overflow_d;
         rx_wait_q   <= rx_wait_d;
      end
   end

   assign io_packet = io_packet_q;
   assign io_valid  = io_valid_q;
   assign overflow  = overflow_q;
   assign rx_wait   = rx_wait_q;

endmodule

// File: tb/tb_mrx_io.sv
// Directed bench for mrx_io: one task per scenario, inline comparisons
// against hand-computed words, masks and cycle timing.
module tb_mrx_io;
   localparam int IOW = 8;

   logic             io_clk;
   logic             nreset;
   logic             rx_en;
   logic             ddr_mode;
   logic             lsbfirst;
   logic [1:0]       iowidth;
   logic             rx_access;
   logic [2*IOW-1:0] rx_packet;
   logic             rx_wait;
   logic [63:0]      io_packet;
   logic [7:0]       io_valid;
   logic             io_wait;
   logic             overflow;

   int errors = 0;
   int checks = 0;

   mrx_io #(.IOW(IOW)) dut (
      .io_clk    (io_clk),
      .nreset    (nreset),
      .rx_en     (rx_en),
      .ddr_mode  (ddr_mode),
      .lsbfirst  (lsbfirst),
      .iowidth   (iowidth),
      .rx_access (rx_access),
      .rx_packet (rx_packet),
      .rx_wait   (rx_wait),
      .io_packet (io_packet),
      .io_valid  (io_valid),
      .io_wait   (io_wait),
      .overflow  (overflow)
   );

   initial io_clk = 1'b0;
   always #5 io_clk = ~io_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic drive(input logic acc, input logic [7:0] rise, input logic [7:0] fall);
      @(negedge io_clk);
      rx_access = acc;
      rx_packet = {fall, rise};
   endtask

   task automatic configure(input logic ddr, input logic lsb, input logic [1:0] iw);
      @(negedge io_clk);
      rx_en     = 1'b0;
      rx_access = 1'b0;
      ddr_mode  = ddr;
      lsbfirst  = lsb;
      iowidth   = iw;
      @(negedge io_clk);
      rx_en = 1'b1;
   endtask

   task automatic test_reset;
      nreset = 1'b0; rx_en = 1'b0; ddr_mode = 1'b0; lsbfirst = 1'b1;
      iowidth = 2'b00; rx_access = 1'b0; rx_packet = '0; io_wait = 1'b0;
      repeat (2) @(negedge io_clk);
      checks++; if (io_valid !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h want 00", io_valid); end
      checks++; if (io_packet !== 64'd0) begin errors++; $display("FAIL reset_packet: got %h want 0", io_packet); end
      checks++; if (rx_wait !== 1'b0) begin errors++; $display("FAIL reset_rx_wait: got %b want 0", rx_wait); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      nreset = 1'b1;
   endtask

   task automatic test_full_sdr;
      configure(1'b0, 1'b1, 2'b00);
      for (int i = 0; i < 8; i++) drive(1'b1, 8'(i), 8'h00);
      drive(1'b0, 8'h00, 8'h00);
      @(negedge io_clk);
      checks++; if (io_valid !== 8'hFF) begin errors++; $display("FAIL sdr_valid: got %h want ff", io_valid); end
      checks++; if (io_packet !== 64'h0706050403020100) begin errors++; $display("FAIL sdr_packet: got %h want 0706050403020100", io_packet); end
      @(negedge io_clk);
      checks++; if (io_valid !== 8'h00) begin errors++; $display("FAIL sdr_drain: got %h want 00", io_valid); end
   endtask

   task automatic test_ddr_msb;
      configure(1'b1, 1'b0, 2'b00);
      drive(1'b1, 8'h11, 8'h22);
      drive(1'b1, 8'h33, 8'h44);
      drive(1'b1, 8'h55, 8'h66);
      drive(1'b1, 8'h77, 8'h88);
      drive(1'b0, 8'h00, 8'h00);
      @(negedge io_clk);
      checks++; if (io_packet !== 64'h1122334455667788 || io_valid !== 8'hFF) begin
         errors++; $display("FAIL ddr_msb: got %h/%h want 1122334455667788/ff", io_packet, io_valid); end
   endtask

   task automatic test_tail;
      logic [11:0] pat;
      configure(1'b0, 1'b1, 2'b00);
      drive(1'b1, 8'hAA, 8'h00);
      drive(1'b1, 8'hBB, 8'h00);
      drive(1'b1, 8'hCC, 8'h00);
      drive(1'b0, 8'h00, 8'h00);
      @(negedge io_clk);
      checks++; if (io_valid !== 8'h00) begin errors++; $display("FAIL tail_early: got %h want 00", io_valid); end
      @(negedge io_clk);
      checks++; if (io_packet !== 64'h0000000000CCBBAA || io_valid !== 8'h07) begin
         errors++; $display("FAIL tail_w8: got %h/%h want 0000000000ccbbaa/07", io_packet, io_valid); end
      configure(1'b0, 1'b1, 2'b11);
      pat = 12'hA5C;
      for (int i = 0; i < 12; i++) drive(1'b1, {7'd0, pat[i]}, 8'h00);
      drive(1'b0, 8'h00, 8'h00);
      repeat (2) @(negedge io_clk);
      checks++; if (io_packet !== 64'h0000000000000A5C || io_valid !== 8'h03) begin
         errors++; $display("FAIL tail_w1: got %h/%h want 0000000000000a5c/03", io_packet, io_valid); end
   endtask

   task automatic test_backpressure;
      configure(1'b0, 1'b1, 2'b00);
      @(negedge io_clk);
      checks++; if (rx_wait !== 1'b0) begin errors++; $display("FAIL bp_idle_wait: got %b want 0", rx_wait); end
      io_wait = 1'b1;
      @(negedge io_clk);
      checks++; if (rx_wait !== 1'b1) begin errors++; $display("FAIL bp_rx_wait: got %b want 1", rx_wait); end
      for (int i = 0; i < 8; i++) drive(1'b1, 8'h10 + 8'(i), 8'h00);
      drive(1'b0, 8'h00, 8'h00);
      @(negedge io_clk);
      checks++; if (io_packet !== 64'h1716151413121110 || io_valid !== 8'hFF) begin
         errors++; $display("FAIL bp_first: got %h/%h want 1716151413121110/ff", io_packet, io_valid); end
      repeat (3) @(negedge io_clk);
      checks++; if (io_packet !== 64'h1716151413121110 || io_valid !== 8'hFF || overflow !== 1'b0) begin
         errors++; $display("FAIL bp_hold: got %h/%h ovf=%b want 1716151413121110/ff ovf=0", io_packet, io_valid, overflow); end
      for (int i = 0; i < 8; i++) drive(1'b1, 8'h20 + 8'(i), 8'h00);
      drive(1'b0, 8'h00, 8'h00);
      @(negedge io_clk);
      checks++; if (overflow !== 1'b1 || io_packet !== 64'h1716151413121110 || io_valid !== 8'hFF) begin
         errors++; $display("FAIL bp_overflow: got ovf=%b %h/%h want ovf=1 1716151413121110/ff", overflow, io_packet, io_valid); end
      io_wait = 1'b0;
      @(negedge io_clk);
      checks++; if (io_valid !== 8'h00) begin errors++; $display("FAIL bp_drain: got %h want 00", io_valid); end
      @(negedge io_clk);
      checks++; if (rx_wait !== 1'b0) begin errors++; $display("FAIL bp_release_wait: got %b want 0", rx_wait); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_sticky: got %b want 1", overflow); end
      rx_en = 1'b0;
      @(negedge io_clk);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_clear: got %b want 0", overflow); end
      rx_en = 1'b1;
   endtask

   task automatic test_back_to_back;
      logic [63:0] exp_q[$];
      logic [63:0] model;
      logic        r, f;
      int          nbits, got;
      configure(1'b1, 1'b0, 2'b11);
      model = 64'd0; nbits = 0; got = 0;
      for (int t = 0; t < 264; t++) begin
         @(negedge io_clk);
         if (io_valid !== 8'h00) begin
            checks++;
            if (got >= exp_q.size()) begin
               errors++; $display("FAIL stream_extra: word %0d at cycle %0d, only %0d expected", got, t, exp_q.size());
            end else if (io_packet !== exp_q[got] || io_valid !== 8'hFF || t != 33 + 32 * got) begin
               errors++; $display("FAIL stream_word%0d: got %h/%h at cycle %0d want %h/ff at cycle %0d",
                                  got, io_packet, io_valid, t, exp_q[got], 33 + 32 * got);
            end
            got++;
         end
         if (t < 256) begin
            r = 1'($urandom_range(0, 1));
            f = 1'($urandom_range(0, 1));
            rx_access = 1'b1;
            rx_packet = {7'd0, f, 7'd0, r};
            model = {model[61:0], r, f};
            nbits += 2;
            if (nbits == 64) begin
               exp_q.push_back(model);
               model = 64'd0;
               nbits = 0;
            end
         end else begin
            rx_access = 1'b0;
         end
      end
      checks++; if (got != 8) begin errors++; $display("FAIL stream_count: got %0d words want 8", got); end
   endtask

   task automatic test_reset_midword;
      configure(1'b0, 1'b1, 2'b00);
      io_wait = 1'b1;
      for (int i = 0; i < 8; i++) drive(1'b1, 8'h30 + 8'(i), 8'h00);
      drive(1'b0, 8'h00, 8'h00);
      @(negedge io_clk);
      checks++; if (io_valid !== 8'hFF) begin errors++; $display("FAIL rst_pre_valid: got %h want ff", io_valid); end
      drive(1'b1, 8'h55, 8'h00);
      drive(1'b1, 8'h66, 8'h00);
      drive(1'b1, 8'h77, 8'h00);
      #2;
      nreset = 1'b0;
      #1;
      checks++; if (io_valid !== 8'h00 || io_packet !== 64'd0 || rx_wait !== 1'b0 || overflow !== 1'b0) begin
         errors++; $display("FAIL rst_mid: got %h/%h wait=%b ovf=%b want all 0", io_packet, io_valid, rx_wait, overflow); end
      @(negedge io_clk);
      nreset = 1'b1; io_wait = 1'b0; rx_access = 1'b0;
      for (int i = 0; i < 8; i++) drive(1'b1, 8'h40 + 8'(i), 8'h00);
      drive(1'b0, 8'h00, 8'h00);
      @(negedge io_clk);
      checks++; if (io_packet !== 64'h4746454443424140 || io_valid !== 8'hFF) begin
         errors++; $display("FAIL rst_next_frame: got %h/%h want 4746454443424140/ff", io_packet, io_valid); end
   endtask

   initial begin
      test_reset();
      test_full_sdr();
      test_ddr_msb();
      test_tail();
      test_backpressure();
      test_back_to_back();
      test_reset_midword();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
